// File: rtl/demux_stream_pkg.sv
// Shared types for the stream demultiplexer.
// The FSM only tracks whether a multi-beat burst currently holds a channel.
package demux_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } demux_state_e;

endpackage

// File: rtl/demux_stream_prm_if.sv
// Producer-side and consumer-side stream signals of the demultiplexer.
// The slave modport is the demux view; the master modport is the surrounding logic.
interface demux_stream_prm_if #(
    parameter int SEL_WIDTH = 2,
    parameter int DAT_WIDTH = 2
);
    localparam int N = 2 ** SEL_WIDTH;

    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [SEL_WIDTH-1:0]          in_sel_i;
    logic                          in_last_i;
    logic [DAT_WIDTH-1:0]          in_dat_i;
    logic [N-1:0]                  out_valid_o;
    logic [N-1:0]                  out_ready_i;
    logic [N-1:0]                  out_last_o;
    logic [N-1:0][DAT_WIDTH-1:0]   out_dat_o;

    modport slave (
        input  in_valid_i, in_sel_i, in_last_i, in_dat_i, out_ready_i,
        output in_ready_o, out_valid_o, out_last_o, out_dat_o
    );

    modport master (
        output in_valid_i, in_sel_i, in_last_i, in_dat_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_last_o, out_dat_o
    );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register slice for a single demux channel.
// A push in the same cycle as a pop keeps the slot full, giving one beat per cycle.
module demux_out_slot #(
    parameter int DAT_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DAT_WIDTH-1:0] dat_i,
    input  logic                 last_i,
    output logic                 valid_o,
    output logic                 last_o,
    output logic [DAT_WIDTH-1:0] dat_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            dat_o   <= '0;
        end else if (push_i) begin
            valid_o <= 1'b1;
            last_o  <= last_i;
            dat_o   <= dat_i;
        end else if (pop_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_prm.sv
// 1-to-2**SEL_WIDTH stream demultiplexer with burst channel locking.
//   state | meaning
//   IDLE  | no burst open; each beat is routed by in_sel_i
//   BURST | burst open; beats go to the locked channel until the last beat
module demux_stream_prm
    import demux_stream_pkg::*;
#(
    parameter int SEL_WIDTH = 2,
    parameter int DAT_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    demux_stream_prm_if.slave    bus,
    output logic                 busy_o,
    output logic [SEL_WIDTH-1:0] cur_sel_o,
    output logic                 sel_err_o
);

    localparam int N = 2 ** SEL_WIDTH;

    demux_state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]        cur_sel_q, cur_sel_d;
    logic                        sel_err_q, sel_err_d;
    logic [SEL_WIDTH-1:0]        rsel;
    logic                        acc;
    logic [N-1:0]                push;
    logic [N-1:0]                slot_valid;
    logic [N-1:0]                slot_last;
    logic [N-1:0][DAT_WIDTH-1:0] slot_dat;

    // Ready follows the consumer combinationally so a full slot can refill on its pop cycle.
    always_comb begin
        rsel           = (state_q == BURST) ? cur_sel_q : bus.in_sel_i;
        bus.in_ready_o = !slot_valid[rsel] | bus.out_ready_i[rsel];
        acc            = bus.in_valid_i & bus.in_ready_o;
        for (int k = 0; k < N; k++) begin
            push[k] = acc && (rsel == SEL_WIDTH'(k));
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_out_slot #(
            .DAT_WIDTH (DAT_WIDTH)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .push_i  (push[k]),
            .pop_i   (bus.out_ready_i[k]),
            .dat_i   (bus.in_dat_i),
            .last_i  (bus.in_last_i),
            .valid_o (slot_valid[k]),
            .last_o  (slot_last[k]),
            .dat_o   (slot_dat[k])
        );
    end

    assign bus.out_valid_o = slot_valid;
    assign bus.out_last_o  = slot_last;
    assign bus.out_dat_o   = slot_dat;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        sel_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc && !bus.in_last_i) begin
                    state_d   = BURST;
                    cur_sel_d = bus.in_sel_i;
                end
            end
            BURST: begin
                // A mismatching select is flagged but the beat still follows the lock.
                sel_err_d = acc && (bus.in_sel_i != cur_sel_q);
                if (acc && bus.in_last_i) begin
                    state_d   = IDLE;
                    cur_sel_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy_o    = (state_q == BURST);
        cur_sel_o = cur_sel_q;
        sel_err_o = sel_err_q;
    end

endmodule
